reg_file_mp: RTL and testbench

//  Parametrised multi-port integer register file, successor to the single-write/dual-read RV32I file.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rf_read_port.sv | 36 +++
 rtl/reg_file_mp.sv | 89 ++++++++
 tb/tb_reg_file_mp.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_e;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port: write-bypass select plus zero/ready masking
module rf_read_port #(
    parameter int XLEN      = 32,
    parameter int AW        = 5,
    parameter int NWR       = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 1
) (
    input  logic [AW-1:0]       raddr,
    input  logic                ready,
    input  logic [XLEN-1:0]     arr_data,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    output logic [XLEN-1:0]     rdata
);

    logic [XLEN-1:0] sel;

    always_comb begin
        sel = arr_data;
        // Ascending scan lets the highest-index matching write port win.
        if (BYPASS != 0) begin
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && (waddr[p*AW +: AW] == raddr)) begin
                    sel = wdata[p*XLEN +: XLEN];
                end
            end
        end
        rdata = '0;
        if (ready && !((ZERO_REG0 != 0) && (raddr == '0))) begin
            rdata = sel;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with priority writes, bypass and clear sweep
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN      = RF_XLEN,
    parameter int NREGS     = RF_NREGS,
    parameter int NRD       = 2,
    parameter int NWR       = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_req,
    output logic                ready,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);

    rf_state_e       state_q, state_d;
    logic [AW:0]     clr_idx_q, clr_idx_d;
    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    assign ready = (state_q == RF_IDLE);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_d     = mem_q;
        case (state_q)
            RF_CLEAR: begin
                mem_d[clr_idx_q[AW-1:0]] = '0;
                clr_idx_d = clr_idx_q + (AW+1)'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                // Writes in the cycle that requests a clear still land; the sweep wipes them.
                for (int p = 0; p < NWR; p++) begin
                    if (we[p] && !((ZERO_REG0 != 0) && (waddr[p*AW +: AW] == '0))) begin
                        mem_d[waddr[p*AW +: AW]] = wdata[p*XLEN +: XLEN];
                    end
                end
                if (clr_req) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            mem_q     <= mem_d;
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        rf_read_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .NWR      (NWR),
            .BYPASS   (BYPASS),
            .ZERO_REG0(ZERO_REG0)
        ) u_rd (
            .raddr   (raddr[r*AW +: AW]),
            .ready   (ready),
            .arr_data(mem_q[raddr[r*AW +: AW]]),
            .we      (we),
            .waddr   (waddr),
            .wdata   (wdata),
            .rdata   (rdata[r*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed bench for reg_file_mp with bypass on and off
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_req;
    logic        ready, ready_nb;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata, rdata_nb;

    int tests = 0;
    int fails = 0;
    int cnt;

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
        .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_nb),
        .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_nb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        cnt = 0;
        while (!ready && cnt < 100) begin
            step();
            cnt++;
        end
        chk(tag, cnt, 32);
    endtask

    initial begin
        rst_n = 1'b0; clr_req = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0;

        // 1: reset then a 32-cycle sweep
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_ready0", {31'd0, ready}, 0);
        chk("rst_rdata_masked", rdata[31:0], 0);
        wait_ready("rst_sweep_len");
        chk("rst_nb_ready", {31'd0, ready_nb}, 1);
        raddr = {5'd9, 5'd5};
        #1;
        chk("rst_rd0", rdata[31:0], 0);
        chk("rst_rd1", rdata[63:32], 0);

        // 2: write/read, bypass vs. no bypass
        we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF; raddr = {5'd5, 5'd5};
        #1;
        chk("wr_bypass_same", rdata[31:0], 32'hDEADBEEF);
        chk("wr_nobypass_same", rdata_nb[31:0], 0);
        step();
        we = 2'b00;
        #1;
        chk("wr_next", rdata[31:0], 32'hDEADBEEF);
        chk("wr_nb_next", rdata_nb[63:32], 32'hDEADBEEF);

        // 3: two ports to the same address, port 1 wins
        we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; raddr = {5'd7, 5'd7};
        #1;
        chk("conf_bypass", rdata[63:32], 32'h22);
        chk("conf_nb_old", rdata_nb[63:32], 0);
        step();
        we = 2'b00;
        #1;
        chk("conf_reg7", rdata[31:0], 32'h22);
        chk("conf_nb_reg7", rdata_nb[31:0], 32'h22);

        // 4: register 0 stays zero
        we = 2'b10; waddr = {5'd0, 5'd0}; wdata = {32'hFFFF_FFFF, 32'h0}; raddr = {5'd0, 5'd0};
        #1;
        chk("x0_same", rdata[31:0], 0);
        step();
        we = 2'b00;
        #1;
        chk("x0_next", rdata[63:32], 0);
        chk("x0_nb_next", rdata_nb[31:0], 0);

        // 5: fill 1..31, then clear with writes and a second clr_req during the sweep
        for (int i = 1; i < 32; i++) begin
            we = 2'b01; waddr[4:0] = 5'(i); wdata[31:0] = 32'(i);
            step();
        end
        we = 2'b00; raddr = {5'd17, 5'd31};
        #1;
        chk("fill_r31", rdata[31:0], 31);
        chk("fill_r17", rdata[63:32], 17);
        clr_req = 1'b1; we = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'hAB;
        step();
        clr_req = 1'b0; waddr[4:0] = 5'd9; wdata[31:0] = 32'h99;
        chk("clr_ready0", {31'd0, ready}, 0);
        cnt = 0;
        while (!ready && cnt < 100) begin
            if (cnt == 5) clr_req = 1'b1;
            step();
            clr_req = 1'b0;
            cnt++;
            if (cnt == 3) chk("clr_rd_masked", rdata[31:0], 0);
        end
        we = 2'b00;
        chk("clr_sweep_len", cnt, 32);
        for (int i = 0; i < 32; i++) begin
            raddr[4:0] = 5'(i);
            #1;
            chk($sformatf("clr_reg%0d", i), rdata[31:0], 0);
        end

        // 6: reset 10 cycles into a sweep restarts it
        we = 2'b01; waddr[4:0] = 5'd4; wdata[31:0] = 32'h44;
        step();
        we = 2'b00; raddr[4:0] = 5'd4;
        #1;
        chk("r6_reg4", rdata[31:0], 32'h44);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("r6_ready0", {31'd0, ready}, 0);
        wait_ready("r6_sweep_len");
        chk("r6_reg4_clr", rdata[31:0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
